lvds_tx_iq_serializer: RTL



---
 rtl/lvds_tx_pkg.sv | 31 +++
 rtl/iq_pair_prefetch.sv | 72 +++++++
 rtl/lvds_tx_iq_serializer.sv | 114 +++++++++++
 3 files changed

// File: rtl/lvds_tx_pkg.sv
// Shared constants, state types and frame packing for the LVDS TX IQ serializer.
package lvds_tx_pkg;

  localparam logic [1:0] SYNC_I = 2'b10;
  localparam logic [1:0] SYNC_Q = 2'b01;

  localparam int FRAME_BITS  = 32;
  localparam int DIBITS      = 16;
  localparam int SAMPLE_BITS = 13;

  typedef enum logic [1:0] {
    P_I,
    P_GAP,
    P_Q,
    P_FULL
  } prefetch_state_t;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } shift_state_t;

  // Radio IQ word, MSB first: sync, 13-bit sample, pad bit, for I then Q.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [SAMPLE_BITS-1:0] i_smp,
    input logic [SAMPLE_BITS-1:0] q_smp
  );
    return {SYNC_I, i_smp, 1'b0, SYNC_Q, q_smp, 1'b0};
  endfunction

endpackage

// File: rtl/iq_pair_prefetch.sv
// Pops I then Q from the FWFT sample FIFO (one idle cycle between reads) and
// holds the pair until the shifter takes it.
module iq_pair_prefetch
  import lvds_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_en,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  input  logic                   load,
  output logic                   fifo_rd_en,
  output logic                   hold_valid,
  output logic [SAMPLE_BITS-1:0] hold_i,
  output logic [SAMPLE_BITS-1:0] hold_q
);

  prefetch_state_t        state_reg;
  logic [SAMPLE_BITS-1:0] hold_i_reg;
  logic [SAMPLE_BITS-1:0] hold_q_reg;
  logic                   pop_i;
  logic                   pop_q;
  logic                   unused_upper_bits;

  // Once I is taken the pair is always completed, so tx_en only gates the I pop.
  assign pop_i      = (state_reg == P_I) && tx_en && !fifo_empty;
  assign pop_q      = (state_reg == P_Q) && !fifo_empty;
  assign fifo_rd_en = !rst && (pop_i || pop_q);

  assign hold_valid = (state_reg == P_FULL);
  assign hold_i     = hold_i_reg;
  assign hold_q     = hold_q_reg;

  assign unused_upper_bits = ^fifo_data[DATA_WIDTH-1:SAMPLE_BITS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= P_I;
      hold_i_reg <= '0;
      hold_q_reg <= '0;
    end else begin
      case (state_reg)
        P_I: begin
          if (pop_i) begin
            hold_i_reg <= fifo_data[SAMPLE_BITS-1:0];
            state_reg  <= P_GAP;
          end
        end
        P_GAP: begin
          state_reg <= P_Q;
        end
        P_Q: begin
          if (pop_q) begin
            hold_q_reg <= fifo_data[SAMPLE_BITS-1:0];
            state_reg  <= P_FULL;
          end
        end
        P_FULL: begin
          if (load) begin
            state_reg <= P_I;
          end
        end
        default: begin
          state_reg <= P_I;
        end
      endcase
    end
  end

endmodule

// File: rtl/lvds_tx_iq_serializer.sv
// Frames prefetched I/Q pairs into 32-bit radio words and shifts them out two
// bits per clock to the DDR output stage; tracks underrun episodes.
module lvds_tx_iq_serializer
  import lvds_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tx_en_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_rd_en_o,
  output logic [1:0]            lvds_d_o,
  output logic                  frame_strobe_o,
  output logic                  busy_o,
  output logic                  underrun_o,
  output logic [CNT_WIDTH-1:0]  underrun_cnt_o,
  input  logic                  underrun_clr_i
);

  shift_state_t           shift_state_reg;
  logic [FRAME_BITS-1:0]  shift_reg;
  logic [4:0]             dibit_cnt_reg;
  logic [1:0]             lvds_d_reg;
  logic                   frame_strobe_reg;
  logic                   streaming_reg;
  logic                   underrun_reg;
  logic [CNT_WIDTH-1:0]   underrun_cnt_reg;

  logic                   hold_valid;
  logic [SAMPLE_BITS-1:0] hold_i;
  logic [SAMPLE_BITS-1:0] hold_q;
  logic [FRAME_BITS-1:0]  next_frame;
  logic                   last_dibit;
  logic                   load;
  logic                   episode;

  iq_pair_prefetch #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_prefetch (
    .clk        (clk_i),
    .rst        (rst_i),
    .tx_en      (tx_en_i),
    .fifo_empty (fifo_empty_i),
    .fifo_data  (fifo_data_i),
    .load       (load),
    .fifo_rd_en (fifo_rd_en_o),
    .hold_valid (hold_valid),
    .hold_i     (hold_i),
    .hold_q     (hold_q)
  );

  assign next_frame = build_frame(hold_i, hold_q);
  assign last_dibit = (shift_state_reg == S_SHIFT) && (dibit_cnt_reg == 5'(DIBITS - 1));
  // Loading from the last dibit keeps back-to-back frames gapless on the line.
  assign load       = hold_valid && ((shift_state_reg == S_IDLE) || last_dibit);
  assign episode    = last_dibit && !hold_valid && tx_en_i && streaming_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_state_reg  <= S_IDLE;
      shift_reg        <= '0;
      dibit_cnt_reg    <= '0;
      lvds_d_reg       <= 2'b00;
      frame_strobe_reg <= 1'b0;
    end else begin
      frame_strobe_reg <= 1'b0;
      if (load) begin
        shift_state_reg  <= S_SHIFT;
        lvds_d_reg       <= next_frame[FRAME_BITS-1 -: 2];
        shift_reg        <= {next_frame[FRAME_BITS-3:0], 2'b00};
        dibit_cnt_reg    <= '0;
        frame_strobe_reg <= 1'b1;
      end else if ((shift_state_reg == S_SHIFT) && !last_dibit) begin
        lvds_d_reg    <= shift_reg[FRAME_BITS-1 -: 2];
        shift_reg     <= {shift_reg[FRAME_BITS-3:0], 2'b00};
        dibit_cnt_reg <= dibit_cnt_reg + 5'd1;
      end else begin
        shift_state_reg <= S_IDLE;
        lvds_d_reg      <= 2'b00;
      end
    end
  end

  // Streaming arms on each load so start-up starvation never counts as underrun.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      streaming_reg    <= 1'b0;
      underrun_reg     <= 1'b0;
      underrun_cnt_reg <= '0;
    end else begin
      underrun_reg <= episode;
      if (load) begin
        streaming_reg <= 1'b1;
      end else if (episode || (!tx_en_i && (shift_state_reg == S_IDLE))) begin
        streaming_reg <= 1'b0;
      end
      if (underrun_clr_i) begin
        underrun_cnt_reg <= '0;
      end else if (episode && (underrun_cnt_reg != '1)) begin
        underrun_cnt_reg <= underrun_cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign lvds_d_o       = lvds_d_reg;
  assign frame_strobe_o = frame_strobe_reg;
  assign busy_o         = (shift_state_reg == S_SHIFT) || hold_valid;
  assign underrun_o     = underrun_reg;
  assign underrun_cnt_o = underrun_cnt_reg;

endmodule
